// File: rtl/memory_access_stage.sv
// Memory access stage: passes ALU results through or runs one LD/ST bus transaction
// with a request/ack handshake and a wait-state timeout, then reports to writeback.
module memory_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 15,
   parameter bit          ALIGN_CHECK    = 1'b1
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        InValid,
   output logic        InReady,
   input  logic [1:0]  MemOp,
   input  logic [31:0] AluResult,
   input  logic [31:0] StoreData,
   input  logic [4:0]  DestReg,
   output logic        BusReq,
   output logic        BusWrite,
   output logic [31:0] BusAddr,
   output logic [31:0] BusWData,
   input  logic        BusAck,
   input  logic [31:0] BusRData,
   output logic        OutValid,
   output logic [31:0] OutData,
   output logic [4:0]  OutDestReg,
   output logic        OutFault
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [0:0] {StIdle, StBus} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_write_q, bus_write_d;
   logic [31:0]       bus_addr_q, bus_addr_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic [4:0]        dest_q, dest_d;
   logic              out_valid_q, out_valid_d;
   logic              out_fault_q, out_fault_d;
   logic [31:0]       out_data_q, out_data_d;
   logic [4:0]        out_dest_q, out_dest_d;
   logic              accept;
   logic              misaligned;

   assign InReady    = (state_q == StIdle) & ~Reset;
   assign accept     = InValid & InReady;
   assign misaligned = ALIGN_CHECK && (AluResult[1:0] != 2'b00);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bus_req_d   = bus_req_q;
      bus_write_d = bus_write_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      dest_d      = dest_q;
      out_valid_d = 1'b0;
      out_fault_d = 1'b0;
      out_data_d  = out_data_q;
      out_dest_d  = out_dest_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (MemOp == 2'b00) begin
                  out_valid_d = 1'b1;
                  out_data_d  = AluResult;
                  out_dest_d  = DestReg;
               end else if (MemOp == 2'b11 || misaligned) begin
                  out_valid_d = 1'b1;
                  out_fault_d = 1'b1;
                  out_data_d  = 32'd0;
                  out_dest_d  = DestReg;
               end else begin
                  state_d     = StBus;
                  cnt_d       = '0;
                  bus_req_d   = 1'b1;
                  bus_write_d = (MemOp == 2'b10);
                  bus_addr_d  = {AluResult[31:2], 2'b00};
                  bus_wdata_d = StoreData;
                  dest_d      = DestReg;
               end
            end
         end
         StBus: begin
            // Ack takes priority over a timeout in the same cycle.
            if (BusAck) begin
               state_d     = StIdle;
               bus_req_d   = 1'b0;
               out_valid_d = 1'b1;
               out_data_d  = bus_write_q ? 32'd0 : BusRData;
               out_dest_d  = bus_write_q ? 5'd31 : dest_q;
            end else if (cnt_q == CntLast) begin
               state_d     = StIdle;
               bus_req_d   = 1'b0;
               out_valid_d = 1'b1;
               out_fault_d = 1'b1;
               out_data_d  = 32'd0;
               out_dest_d  = dest_q;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         bus_req_q   <= 1'b0;
         bus_write_q <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_wdata_q <= 32'd0;
         dest_q      <= 5'd0;
         out_valid_q <= 1'b0;
         out_fault_q <= 1'b0;
         out_data_q  <= 32'd0;
         out_dest_q  <= 5'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_write_q <= bus_write_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         dest_q      <= dest_d;
         out_valid_q <= out_valid_d;
         out_fault_q <= out_fault_d;
         out_data_q  <= out_data_d;
         out_dest_q  <= out_dest_d;
      end
   end

   assign BusReq     = bus_req_q;
   assign BusWrite   = bus_write_q;
   assign BusAddr    = bus_addr_q;
   assign BusWData   = bus_wdata_q;
   assign OutValid   = out_valid_q;
   assign OutFault   = out_fault_q;
   assign OutData    = out_data_q;
   assign OutDestReg = out_dest_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: pass-through, LD/ST handshakes, faults,
// timeout boundary and reset during a bus transaction.
module tb_memory_access_stage;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        InValid;
   logic        InReady;
   logic [1:0]  MemOp;
   logic [31:0] AluResult;
   logic [31:0] StoreData;
   logic [4:0]  DestReg;
   logic        BusReq;
   logic        BusWrite;
   logic [31:0] BusAddr;
   logic [31:0] BusWData;
   logic        BusAck;
   logic [31:0] BusRData;
   logic        OutValid;
   logic [31:0] OutData;
   logic [4:0]  OutDestReg;
   logic        OutFault;

   int n_total = 0;
   int n_pass  = 0;
   int req_cycles;

   memory_access_stage #(
      .TIMEOUT_CYCLES(15),
      .ALIGN_CHECK   (1'b1)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .InValid   (InValid),
      .InReady   (InReady),
      .MemOp     (MemOp),
      .AluResult (AluResult),
      .StoreData (StoreData),
      .DestReg   (DestReg),
      .BusReq    (BusReq),
      .BusWrite  (BusWrite),
      .BusAddr   (BusAddr),
      .BusWData  (BusWData),
      .BusAck    (BusAck),
      .BusRData  (BusRData),
      .OutValid  (OutValid),
      .OutData   (OutData),
      .OutDestReg(OutDestReg),
      .OutFault  (OutFault)
   );

   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, got, exp);
   endtask

   task automatic drive_op(input logic [1:0] op, input logic [31:0] alu,
                           input logic [31:0] sd, input logic [4:0] dst);
      InValid   = 1'b1;
      MemOp     = op;
      AluResult = alu;
      StoreData = sd;
      DestReg   = dst;
   endtask

   task automatic idle_in();
      InValid = 1'b0;
      MemOp   = 2'b00;
   endtask

   // Counts BusReq cycles, raising BusAck on the ack_at-th one (0 = never), bounded.
   task automatic run_bus(input int ack_at, input logic [31:0] rdata, output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (!BusReq) break;
         n++;
         if (n == ack_at) begin
            BusAck   = 1'b1;
            BusRData = rdata;
         end
         tick();
         BusAck   = 1'b0;
         BusRData = 32'd0;
      end
   endtask

   initial begin
      Reset = 1'b1;
      InValid = 1'b0; MemOp = 2'b00; AluResult = '0; StoreData = '0; DestReg = '0;
      BusAck = 1'b0; BusRData = '0;
      tick();
      tick();
      chk("rst_inready", InReady, 0);
      chk("rst_busreq", BusReq, 0);
      chk("rst_outvalid", OutValid, 0);
      chk("rst_outfault", OutFault, 0);
      chk("rst_outdata", OutData, 0);
      chk("rst_busaddr", BusAddr, 0);
      chk("rst_outdest", OutDestReg, 0);
      Reset = 1'b0;
      #1;
      chk("rel_inready", InReady, 1);

      // Back-to-back pass ops
      drive_op(2'b00, 32'd1, 32'd0, 5'd5);
      tick();
      chk("pass1_valid", OutValid, 1);
      chk("pass1_data", OutData, 1);
      chk("pass1_dest", OutDestReg, 5);
      chk("pass1_ready", InReady, 1);
      drive_op(2'b00, 32'd2, 32'd0, 5'd6);
      tick();
      chk("pass2_valid", OutValid, 1);
      chk("pass2_data", OutData, 2);
      chk("pass2_ready", InReady, 1);
      drive_op(2'b00, 32'd3, 32'd0, 5'd7);
      tick();
      chk("pass3_valid", OutValid, 1);
      chk("pass3_data", OutData, 3);
      chk("pass3_dest", OutDestReg, 7);
      idle_in();
      tick();
      chk("pass_end_valid", OutValid, 0);
      chk("pass_hold_data", OutData, 3);

      // LD 0x100, ack on 3rd BusReq cycle
      drive_op(2'b01, 32'h100, 32'hAAAA_5555, 5'd9);
      tick();
      idle_in();
      chk("ld_busreq", BusReq, 1);
      chk("ld_buswrite", BusWrite, 0);
      chk("ld_busaddr", BusAddr, 32'h100);
      chk("ld_inready", InReady, 0);
      chk("ld_novalid", OutValid, 0);
      run_bus(3, 32'hDEAD_BEEF, req_cycles);
      chk("ld_req_cycles", req_cycles, 3);
      chk("ld_valid", OutValid, 1);
      chk("ld_data", OutData, 32'hDEAD_BEEF);
      chk("ld_fault", OutFault, 0);
      chk("ld_dest", OutDestReg, 9);
      chk("ld_inready_back", InReady, 1);

      // ST 0x104, accepted in OutValid cycle, immediate ack
      drive_op(2'b10, 32'h104, 32'h1234_5678, 5'd3);
      tick();
      idle_in();
      chk("st_busreq", BusReq, 1);
      chk("st_buswrite", BusWrite, 1);
      chk("st_busaddr", BusAddr, 32'h104);
      chk("st_wdata", BusWData, 32'h1234_5678);
      chk("st_novalid", OutValid, 0);
      run_bus(1, 32'hFFFF_FFFF, req_cycles);
      chk("st_req_cycles", req_cycles, 1);
      chk("st_valid", OutValid, 1);
      chk("st_dest", OutDestReg, 31);
      chk("st_data", OutData, 0);
      chk("st_fault", OutFault, 0);

      // Misaligned LD
      drive_op(2'b01, 32'h102, 32'd0, 5'd4);
      tick();
      idle_in();
      chk("mis_busreq", BusReq, 0);
      chk("mis_valid", OutValid, 1);
      chk("mis_fault", OutFault, 1);
      chk("mis_data", OutData, 0);
      chk("mis_ready", InReady, 1);
      tick();
      chk("mis_valid_pulse", OutValid, 0);
      chk("mis_fault_pulse", OutFault, 0);

      // Illegal op
      drive_op(2'b11, 32'h200, 32'd0, 5'd8);
      tick();
      idle_in();
      chk("ill_busreq", BusReq, 0);
      chk("ill_valid", OutValid, 1);
      chk("ill_fault", OutFault, 1);
      chk("ill_data", OutData, 0);
      tick();

      // LD with no ack times out after 15 BusReq cycles
      drive_op(2'b01, 32'h300, 32'd0, 5'd10);
      tick();
      idle_in();
      run_bus(0, 32'd0, req_cycles);
      chk("to_req_cycles", req_cycles, 15);
      chk("to_valid", OutValid, 1);
      chk("to_fault", OutFault, 1);
      chk("to_data", OutData, 0);
      tick();

      // Ack on the 15th cycle beats the timeout
      drive_op(2'b01, 32'h304, 32'd0, 5'd11);
      tick();
      idle_in();
      run_bus(15, 32'hCAFE_F00D, req_cycles);
      chk("lastack_req_cycles", req_cycles, 15);
      chk("lastack_valid", OutValid, 1);
      chk("lastack_fault", OutFault, 0);
      chk("lastack_data", OutData, 32'hCAFE_F00D);
      chk("lastack_dest", OutDestReg, 11);
      tick();

      // Reset during the 2nd BusReq cycle abandons the transaction
      drive_op(2'b01, 32'h400, 32'd0, 5'd12);
      tick();
      idle_in();
      tick();
      chk("rstmid_busreq_before", BusReq, 1);
      Reset = 1'b1;
      tick();
      chk("rstmid_busreq", BusReq, 0);
      chk("rstmid_novalid", OutValid, 0);
      chk("rstmid_inready", InReady, 0);
      Reset = 1'b0;
      #1;
      chk("rstmid_ready_rel", InReady, 1);
      tick();
      chk("rstmid_novalid2", OutValid, 0);
      chk("rstmid_busreq2", BusReq, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
